// File: rtl/fpu_shared_ctrl_pkg.sv
// fpu_defs: shared FPU widths, operation-code enum and tag-width helper
//   C_OP   : operand/result width
//   C_CMD  : operation-code width
//   C_FLAG : IEEE exception flag width
package fpu_defs;
  localparam int C_OP   = 32;
  localparam int C_CMD  = 4;
  localparam int C_FLAG = 5;
  typedef enum logic [C_CMD-1:0] {
    FPU_ADD  = 4'd0,
    FPU_SUB  = 4'd1,
    FPU_MUL  = 4'd2,
    FPU_DIV  = 4'd3,
    FPU_SQRT = 4'd4,
    FPU_I2F  = 4'd5,
    FPU_F2I  = 4'd6,
    FPU_CMP  = 4'd7
  } fpu_op_e;
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fpu_shared_ctrl_arb.sv
// fpu_rr_arb: single-grant arbiter, round-robin with FPU_SHARED_RR_EN, else fixed priority
//   Clk_CI, Rst_RBI : clock / async active-low reset (pointer only, FPU_SHARED_RR_EN builds)
//   En_SI           : allow a grant this cycle
//   Req_SI          : per-requester request
//   Gnt_SO          : one-hot or zero grant
//   Idx_DO          : index of the granted requester
//   Vld_SO          : a grant is asserted
module fpu_rr_arb
  import fpu_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TW      = tag_width(NUM_REQ)
) (
`ifdef FPU_SHARED_RR_EN
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
`endif
  input  logic               En_SI,
  input  logic [NUM_REQ-1:0] Req_SI,
  output logic [NUM_REQ-1:0] Gnt_SO,
  output logic [TW-1:0]      Idx_DO,
  output logic               Vld_SO
);
  assign Vld_SO = |Gnt_SO;
`ifdef FPU_SHARED_RR_EN
  logic [TW-1:0] ptr_q, ptr_d;
  // Search starts at the pointer and wraps; the pointer is always < NUM_REQ
  // so a single conditional subtract replaces the modulo.
  always_comb begin
    Gnt_SO = '0;
    Idx_DO = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (En_SI && Gnt_SO == '0 && Req_SI[j]) begin
        Gnt_SO[j] = 1'b1;
        Idx_DO    = TW'(j);
      end
    end
    ptr_d = (Gnt_SO == '0) ? ptr_q : (Idx_DO == TW'(NUM_REQ - 1)) ? '0 : Idx_DO + 1'b1;
  end
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  always_comb begin
    Gnt_SO = '0;
    Idx_DO = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (En_SI && Req_SI[k]) begin
        Gnt_SO = '0;
        Gnt_SO[k] = 1'b1;
        Idx_DO = TW'(k);
      end
  end
`endif
endmodule

// File: rtl/fpu_shared_ctrl.sv
// fpu_shared_ctrl: shares one pipelined FPU among NUM_REQ requesters
//   Clk_CI/Rst_RBI            : clock, async active-low reset
//   Flush_SI                  : drop all in-flight ops, block grants this cycle
//   Req_SI/Gnt_SO             : per-requester request / one-hot grant
//   Operand_a/b_DI, Op_SI     : per-requester operands and op code
//   Valid_SO/Result_DO/Flags_DO : tagged result return, broadcast data
//   FPU_*_SO/DO               : issue to datapath; FPU_Result/Flags_DI return after C_LATENCY
//   Macro FPU_SHARED_RR_EN    : round-robin arbitration (default fixed priority)
module fpu_shared_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter int C_LATENCY = 2,
  parameter int C_OP      = fpu_defs::C_OP,
  parameter int C_CMD     = fpu_defs::C_CMD,
  parameter int C_FLAG    = fpu_defs::C_FLAG
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic                           Flush_SI,
  input  logic [NUM_REQ-1:0]             Req_SI,
  output logic [NUM_REQ-1:0]             Gnt_SO,
  input  logic [NUM_REQ-1:0][C_OP-1:0]   Operand_a_DI,
  input  logic [NUM_REQ-1:0][C_OP-1:0]   Operand_b_DI,
  input  logic [NUM_REQ-1:0][C_CMD-1:0]  Op_SI,
  output logic [NUM_REQ-1:0]             Valid_SO,
  output logic [C_OP-1:0]                Result_DO,
  output logic [C_FLAG-1:0]              Flags_DO,
  output logic                           FPU_Valid_SO,
  output logic [C_OP-1:0]                FPU_Operand_a_DO,
  output logic [C_OP-1:0]                FPU_Operand_b_DO,
  output logic [C_CMD-1:0]               FPU_Op_SO,
  input  logic [C_OP-1:0]                FPU_Result_DI,
  input  logic [C_FLAG-1:0]              FPU_Flags_DI
);
  localparam int TW = fpu_defs::tag_width(NUM_REQ);
  logic                          arb_en, gnt_vld;
  logic [TW-1:0]                 gnt_idx;
  logic [C_LATENCY-1:0]          pipe_vld_q, pipe_vld_d;
  logic [C_LATENCY-1:0][TW-1:0]  pipe_tag_q, pipe_tag_d;
  logic                          tail_vld;
  // Grants are suppressed while in reset and during a flush cycle.
  assign arb_en = Rst_RBI & ~Flush_SI;
  fpu_rr_arb #(.NUM_REQ(NUM_REQ), .TW(TW)) u_arb (
`ifdef FPU_SHARED_RR_EN
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
`endif
    .En_SI   (arb_en),
    .Req_SI  (Req_SI),
    .Gnt_SO  (Gnt_SO),
    .Idx_DO  (gnt_idx),
    .Vld_SO  (gnt_vld)
  );
  assign tail_vld = pipe_vld_q[C_LATENCY-1];
  always_comb begin
    FPU_Valid_SO     = gnt_vld;
    FPU_Operand_a_DO = gnt_vld ? Operand_a_DI[gnt_idx] : '0;
    FPU_Operand_b_DO = gnt_vld ? Operand_b_DI[gnt_idx] : '0;
    FPU_Op_SO        = gnt_vld ? Op_SI[gnt_idx] : '0;
    Valid_SO         = '0;
    if (tail_vld) Valid_SO[pipe_tag_q[C_LATENCY-1]] = 1'b1;
    Result_DO        = tail_vld ? FPU_Result_DI : '0;
    Flags_DO         = tail_vld ? FPU_Flags_DI : '0;
    pipe_vld_d[0]    = gnt_vld;
    pipe_tag_d[0]    = gnt_idx;
    for (int s = 1; s < C_LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_tag_d[s] = pipe_tag_q[s-1];
    end
    // The tail is still reported combinationally this cycle; only the
    // bits that would survive past the edge are cleared.
    if (Flush_SI) pipe_vld_d = '0;
  end
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) begin
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
endmodule
